// File: rtl/pulse_train_generator.sv
// Turns one accepted command into N pulses of H cycles high separated by L cycles low,
// then raises done for one cycle. Zero-length phases are stretched to one cycle.
module pulse_train_generator #(
  parameter int COUNT_WIDTH = 8,
  parameter int TIME_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [COUNT_WIDTH-1:0] pulse_count,
  input  logic [TIME_WIDTH-1:0]  pulse_high,
  input  logic [TIME_WIDTH-1:0]  pulse_low,
  input  logic                   abort,
  output logic                   pulse_out,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [TIME_WIDTH-1:0]  TIME_ONE  = TIME_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [TIME_WIDTH-1:0]  phase_q, phase_d;
  logic [TIME_WIDTH-1:0]  high_q, high_d;
  logic [TIME_WIDTH-1:0]  low_q, low_d;
  logic [COUNT_WIDTH-1:0] remain_q, remain_d;
  logic                   pulse_q, pulse_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [TIME_WIDTH-1:0]  high_eff;
  logic [TIME_WIDTH-1:0]  low_eff;

  // Zero durations become one cycle so adjacent pulses can never merge.
  assign high_eff = (pulse_high == '0) ? TIME_ONE : pulse_high;
  assign low_eff  = (pulse_low  == '0) ? TIME_ONE : pulse_low;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    phase_d  = phase_q;
    high_d   = high_q;
    low_d    = low_q;
    remain_d = remain_q;
    pulse_d  = pulse_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (start_valid) begin
          high_d = high_eff;
          low_d  = low_eff;
          if (pulse_count == '0) begin
            remain_d = '0;
            done_d   = 1'b1;
          end else begin
            state_d  = HIGH;
            remain_d = pulse_count;
            phase_d  = high_eff - TIME_ONE;
            pulse_d  = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_d  = IDLE;
          phase_d  = '0;
          remain_d = '0;
          pulse_d  = 1'b0;
          busy_d   = 1'b0;
        end else if (phase_q == '0) begin
          remain_d = remain_q - COUNT_ONE;
          pulse_d  = 1'b0;
          if (remain_q == COUNT_ONE) begin
            // Last pulse finished: no trailing low phase, report completion.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            phase_d = low_q - TIME_ONE;
          end
        end else begin
          phase_d = phase_q - TIME_ONE;
        end
      end

      LOW: begin
        if (abort) begin
          state_d  = IDLE;
          phase_d  = '0;
          remain_d = '0;
          pulse_d  = 1'b0;
          busy_d   = 1'b0;
        end else if (phase_q == '0) begin
          state_d = HIGH;
          phase_d = high_q - TIME_ONE;
          pulse_d = 1'b1;
        end else begin
          phase_d = phase_q - TIME_ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        phase_d  = '0;
        remain_d = '0;
        pulse_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      high_q   <= '0;
      low_q    <= '0;
      remain_q <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      phase_q  <= phase_d;
      high_q   <= high_d;
      low_q    <= low_d;
      remain_q <= remain_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign pulse_out   = pulse_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed and randomized stimulus for pulse_train_generator, checked every cycle
// against a model that expands each command into its expected pulse sequence.
module tb_pulse_train_generator;

  localparam int CW = 8;
  localparam int TW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [CW-1:0] pulse_count = '0;
  logic [TW-1:0] pulse_high = '0;
  logic [TW-1:0] pulse_low = '0;
  logic          abort = 1'b0;
  logic          pulse_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  // Model: the remaining pulse bits of the current train, plus expected outputs.
  int   train[$];
  logic m_pulse = 1'b0;
  logic m_busy  = 1'b0;
  logic m_done  = 1'b0;

  pulse_train_generator #(.COUNT_WIDTH(CW), .TIME_WIDTH(TW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pulse_count (pulse_count),
    .pulse_high  (pulse_high),
    .pulse_low   (pulse_low),
    .abort       (abort),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    train.delete();
    m_pulse = 1'b0;
    m_busy  = 1'b0;
    m_done  = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int n, h, l;
    if (!reset_n) begin
      model_reset();
    end else if (m_busy) begin
      m_done = 1'b0;
      if (abort) begin
        model_reset();
      end else if (train.size() == 0) begin
        m_pulse = 1'b0;
        m_busy  = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_pulse = train.pop_front() != 0;
      end
    end else begin
      m_done  = 1'b0;
      m_pulse = 1'b0;
      if (start_valid) begin
        n = int'(pulse_count);
        h = (pulse_high == 0) ? 1 : int'(pulse_high);
        l = (pulse_low == 0) ? 1 : int'(pulse_low);
        train.delete();
        for (int p = 0; p < n; p++) begin
          for (int i = 0; i < h; i++) train.push_back(1);
          if (p < n - 1) for (int i = 0; i < l; i++) train.push_back(0);
        end
        if (n == 0) begin
          m_done = 1'b1;
        end else begin
          m_busy  = 1'b1;
          m_pulse = train.pop_front() != 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pulse_out"},   32'(pulse_out),   32'(m_pulse));
    check({tag, ".busy"},        32'(busy),        32'(m_busy));
    check({tag, ".done"},        32'(done),        32'(m_done));
    check({tag, ".start_ready"}, 32'(start_ready), 32'(!m_busy));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Present a command for exactly one edge, then scramble the fields to prove they were captured.
  task automatic cmd(input string tag, input int n, input int h, input int l);
    start_valid = 1'b1;
    pulse_count = CW'(n);
    pulse_high  = TW'(h);
    pulse_low   = TW'(l);
    step(tag);
    start_valid = 1'b0;
    pulse_count = CW'($urandom);
    pulse_high  = TW'($urandom);
    pulse_low   = TW'($urandom);
  endtask

  task automatic run_until_idle(input string tag);
    int budget = 2000;
    while ((m_busy || m_done) && budget > 0) begin
      step(tag);
      budget--;
    end
    check({tag, ".idle_budget"}, 32'(budget > 0), 32'(1));
    step(tag);
  endtask

  initial begin
    // Reset held, then released with no stimulus.
    #1;
    compare_all("reset_hold");
    repeat (2) step("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) step("idle");

    cmd("basic", 3, 2, 1);
    run_until_idle("basic");

    cmd("n_zero", 0, 4, 4);
    run_until_idle("n_zero");

    cmd("zero_hl", 2, 0, 0);
    run_until_idle("zero_hl");

    // Abort during the second cycle of the first low phase.
    cmd("abort", 5, 3, 3);
    repeat (4) step("abort");
    abort = 1'b1;
    step("abort_edge");
    abort = 1'b0;
    check("abort.no_train", 32'(busy), 32'(0));
    repeat (4) step("abort_after");

    // Abort held in IDLE across a handshake must not block the start.
    abort = 1'b1;
    start_valid = 1'b1;
    pulse_count = 8'd1;
    pulse_high  = 8'd2;
    pulse_low   = 8'd0;
    step("abort_idle");
    start_valid = 1'b0;
    abort = 1'b0;
    run_until_idle("abort_idle");

    // Back-to-back: second command held from the done cycle of the first.
    cmd("b2b_first", 2, 1, 2);
    begin
      int budget = 100;
      while (!m_done && budget > 0) begin
        step("b2b_first");
        budget--;
      end
      check("b2b.done_seen", 32'(done), 32'(1));
    end
    cmd("b2b_second", 1, 1, 0);
    check("b2b.accepted", 32'(pulse_out), 32'(1));
    run_until_idle("b2b_second");

    // Asynchronous reset between edges during a high phase.
    cmd("async", 4, 5, 2);
    repeat (2) step("async");
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    repeat (2) step("async_hold");
    @(negedge clock);
    reset_n = 1'b1;
    step("async_release");
    cmd("async_restart", 2, 1, 1);
    run_until_idle("async_restart");

    // Length boundaries.
    cmd("max_count", 255, 0, 0);
    run_until_idle("max_count");
    cmd("max_high", 1, 255, 0);
    run_until_idle("max_high");

    // Randomized traffic: inputs toggle freely, including while busy.
    for (int c = 0; c < 600; c++) begin
      start_valid = ($urandom_range(0, 2) == 0);
      pulse_count = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 12)) : CW'($urandom_range(0, 4));
      pulse_high  = TW'($urandom_range(0, 4));
      pulse_low   = TW'($urandom_range(0, 4));
      abort       = ($urandom_range(0, 24) == 0);
      step("random");
    end
    start_valid = 1'b0;
    abort = 1'b0;
    run_until_idle("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Level/request-to-pulse counterpart of the pulse latch. The latch turns a transient event into a held level; this block turns a one-time request into a counted train of timed pulses.
- FSMs use it to issue N strobes of programmable high/low width to downstream logic. Downstream logic may capture those strobes with pulse latches.
- Command is accepted by valid/ready handshake; completion is reported by a one-cycle done pulse.

Parameters:
- COUNT_WIDTH, 8, width of pulse-count field; max train length 2^COUNT_WIDTH-1.
- TIME_WIDTH, 8, width of high/low duration fields in clock cycles.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  command present.
- start_ready  output  1  block can accept a command (high only in IDLE).
- pulse_count  input  COUNT_WIDTH  number of pulses N; sampled at handshake.
- pulse_high  input  TIME_WIDTH  high-phase length H in cycles; sampled at handshake.
- pulse_low  input  TIME_WIDTH  low-phase length L between pulses; sampled at handshake.
- abort  input  1  synchronous cancel of a train in progress.
- pulse_out  output  1  registered pulse train.
- busy  output  1  train in progress (HIGH or LOW state).
- done  output  1  one-cycle completion strobe.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - FSM=IDLE.
  - pulse_out=0, busy=0, done=0, start_ready=1.
  - All counters and captured fields = 0.
- States: IDLE, HIGH, LOW. All outputs are registered or decoded from state; start_ready = (state==IDLE).
- Handshake:
  - Accept when start_valid & start_ready at a rising edge (cycle T0).
  - pulse_count, pulse_high and pulse_low are captured at that edge; later input changes are ignored.
- Zero durations: H==0 is treated as H=1; L==0 is treated as L=1. Pulses therefore never merge.
- N==0:
  - No pulses are issued; state stays IDLE.
  - done=1 in cycle T1 only; busy stays 0.
- N>=1:
  - IDLE->HIGH at T0 edge; pulse_out=1 and busy=1 from T1.
  - HIGH lasts exactly H cycles.
  - After the high phase, if pulses remain: HIGH->LOW for exactly L cycles with pulse_out=0, then LOW->HIGH.
  - After the final high phase: HIGH->IDLE with no trailing low phase. In the first IDLE cycle, done=1, busy=0, start_ready=1.
  - Busy duration is exactly N*H + (N-1)*L cycles.
- Counters:
  - The phase counter loads H-1 or L-1 on state entry and decrements to 0.
  - The pulse counter decrements at the end of each high phase.
  - Neither counter wraps; sizes follow the parameters.
- Back-to-back commands: a command presented during the done cycle is accepted. The next train starts the following cycle, with no forced gap beyond the single IDLE cycle.
- Abort:
  - In HIGH or LOW at an edge: next state is IDLE, pulse_out=0, busy=0, done is NOT asserted, and remaining pulses are discarded.
  - In IDLE: ignored, including the cycle of a handshake, so that start is accepted normally.
- Abort on the final cycle of the last high phase: abort wins; no done is issued.
- reset_n asserted mid-train: immediate return to IDLE with reset output values; no done.
- start_valid while busy: held off by start_ready=0. There is no command queue.

Test Plan:
- Reset then idle: release reset_n with no stimulus -> start_ready=1, pulse_out=0, busy=0, done=0 held.
- Basic train: N=3, H=2, L=1 at T0 -> pulse_out over T1..T8 = 1,1,0,1,1,0,1,1; busy high T1..T8; done=1 at T9 only; start_ready=1 at T9.
- Zero cases:
  - N=0 -> done=1 at T1; pulse_out stays 0; busy stays 0.
  - N=2, H=0, L=0 -> pulse_out 1,0,1 over T1..T3; done at T4.
- Abort: N=5, H=3, L=3, abort asserted in the second LOW cycle -> pulse_out=0 and busy=0 next cycle; done never asserted; start_ready=1.
- Back-to-back: a second command (N=1, H=1) held valid from the done cycle of the first train -> accepted in the done cycle; pulse_out=1 one cycle later; second done follows; no lost or extra pulses.
- Async reset mid-train: drop reset_n during a HIGH phase, between edges -> pulse_out and busy go 0 immediately; after release the block is IDLE and accepts a new command.
